mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline stage between execute and `write_back` that performs data-memory loads and stores for the 32-bit RISC-V core. It accepts one instruction at a time from execute and issues a valid/ready request to the data memory. For loads it waits for the response, then aligns and sign- or zero-extends the data. It delivers `alu_result`, `loaded_data`, `dest_reg` and `opcode` to `write_back` as a single-cycle valid pulse.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  execute presents an instruction.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `in_alu_result`  in  32  effective address for load/store; result or immediate otherwise.
- `in_store_data`  in  32  rs2 value for stores.
- `in_dest_reg`  in  5  rd.
- `in_opcode`  in  7  instruction opcode.
- `in_funct3`  in  3  access size and signedness.
- `dmem_req_valid`  out  1  memory request.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_req_addr`  out  32  word-aligned address, {addr[31:2], 2'b00}.
- `dmem_req_we`  out  1  1 = store.
- `dmem_req_be`  out  4  byte enables.
- `dmem_req_wdata`  out  32  lane-replicated store data.
- `dmem_resp_valid`  in  1  load data returned.
- `dmem_resp_data`  in  32  full word read.
- `out_valid`  out  1  one-cycle pulse to `write_back`.
- `out_alu_result`  out  32  registered `in_alu_result`.
- `out_loaded_data`  out  32  extended load data.
- `out_dest_reg`  out  5  rd, or 0 when misaligned.
- `out_opcode`  out  7  registered opcode.
- `out_misaligned`  out  1  access was misaligned; no memory access performed.

## Operation
- FSM states: IDLE, REQ, WAIT. The reset state is IDLE.
- Acceptance:
  - Transfer occurs when `in_valid && in_ready`.
  - All inputs are latched at transfer.
  - `in_valid` while busy is ignored; execute must hold it.
- Classification:
  - Load is opcode 0000011; store is opcode 0100011.
  - LUI (0110111): `out_loaded_data = in_alu_result`.
  - Other non-memory ops: `out_loaded_data = 0`.
  - Non-memory ops go IDLE → IDLE with `out_valid` next cycle.
- Misalignment (checked at acceptance):
  - Halfword (funct3[1:0] = 01) with addr[0] = 1 is misaligned.
  - Word (10) with addr[1:0] ≠ 0 is misaligned.
  - funct3[1:0] = 11 is treated as misaligned.
  - Response: no memory request; `out_valid` next cycle with `out_misaligned = 1`, `out_dest_reg = 0`, `out_loaded_data = 0`.
- Aligned memory op: IDLE → REQ.
- REQ:
  - `dmem_req_*` driven and held stable until `dmem_req_ready`.
  - On handshake, a store goes to IDLE with `out_valid` the next cycle.
  - On handshake, a load goes to WAIT.
- WAIT: on `dmem_resp_valid`, capture, extend, go to IDLE, `out_valid` the next cycle.
- Store lanes (o = addr[1:0]):
  - SB: `be = 4'b0001 << o`, wdata = {4{rs2[7:0]}}.
  - SH: `be = 4'b0011 << (2*addr[1])`, wdata = {2{rs2[15:0]}}.
  - SW: `be = 4'b1111`, wdata = rs2.
- Load extraction:
  - Shift: `d = resp >> (8*o)`.
  - LB: sign-extend d[7:0]. LBU: zero-extend d[7:0].
  - LH: sign-extend d[15:0]. LHU: zero-extend d[15:0].
  - LW: d.
- `dmem_req_we = 0`, `be = 0` for loads.

## Timing
- Reset values:
  - `in_ready = 1`.
  - `dmem_req_valid`, `dmem_req_we`, `out_valid`, `out_misaligned` = 0.
  - All data, address, reg and opcode outputs = 0.
- Outputs are registered; `out_*` payload holds its value until the next `out_valid`.
- Latency from acceptance at cycle T:
  - Non-memory or misaligned: `out_valid` at T+1.
  - Store: `dmem_req_valid` at T+1; with ready that cycle, `out_valid` at T+2.
  - Load: with ready at T+1 and response at T+2, `out_valid` at T+3.
  - Each stall cycle on ready or response adds one cycle.
- `in_ready` is low from T+1 until the cycle `out_valid` is high. A new acceptance may coincide with `out_valid`.
- `dmem_resp_valid` outside WAIT is ignored, including a response arriving in the same cycle as the request handshake.
- `out_valid` is never high for two consecutive cycles for the same instruction. There is no downstream backpressure.
- Reset mid-operation: next cycle is IDLE, `dmem_req_valid` = 0, and no `out_valid` for the aborted instruction.

## Test plan
- ADD, opcode 0110011, alu 0x1234, rd 5 → `out_valid` at T+1, `out_alu_result` 0x1234, `out_loaded_data` 0, `out_dest_reg` 5, no memory request.
- LB at addr 0x103, memory word 0x80FF_0000, ready immediate, response 1 cycle later → `req_addr` 0x100, `out_loaded_data` 0xFFFF_FF80 at T+3. LBU on the same data gives 0x0000_0080.
- SH at addr 0x202, rs2 0xABCD_1234 → `be` 4'b1100, wdata 0x1234_1234, `we` 1, `out_valid` at T+2.
- LW at addr 0x301 → `out_misaligned` 1, `out_dest_reg` 0, no `dmem_req_valid`, `out_valid` at T+1.
- LW with ready low for 3 cycles and response 4 cycles after the handshake → request fields stable throughout, `in_ready` low, exactly one `out_valid`.
- Reset asserted in WAIT, then a stale `dmem_resp_valid` → no `out_valid`, `in_ready` 1 the cycle after reset.
- LUI, alu 0xDEAD_B000 → `out_loaded_data` 0xDEAD_B000.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory loads/stores over a valid/ready
// request channel, then aligns and extends load data before handing off to write_back.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_dest_reg,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [3:0]      dmem_req_be,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_loaded_data,
  output logic [4:0]      out_dest_reg,
  output logic [6:0]      out_opcode,
  output logic            out_misaligned
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic [XLEN-1:0] alu_q;
  logic [4:0]      rd_q;
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  logic            is_load, is_store, size_bad, misaligned;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] shifted, ld_ext;

  assign in_ready = (state == IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_load  = (in_opcode == OP_LOAD);
    is_store = (in_opcode == OP_STORE);
    case (in_funct3[1:0])
      2'b00:   size_bad = 1'b0;
      2'b01:   size_bad = in_alu_result[0];
      2'b10:   size_bad = |in_alu_result[1:0];
      default: size_bad = 1'b1;
    endcase
    misaligned = (is_load || is_store) && size_bad;

    // Replicate store data across lanes; byte enables pick the lanes actually written.
    st_be    = 4'b1111;
    st_wdata = in_store_data;
    case (in_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << in_alu_result[1:0];
        st_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {in_alu_result[1], 1'b0};
        st_wdata = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = dmem_resp_data >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'd0, shifted[7:0]};
      3'b101:  ld_ext = {16'd0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      alu_q           <= '0;
      rd_q            <= '0;
      op_q            <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      dmem_req_valid  <= 1'b0;
      dmem_req_addr   <= '0;
      dmem_req_we     <= 1'b0;
      dmem_req_be     <= '0;
      dmem_req_wdata  <= '0;
      out_valid       <= 1'b0;
      out_alu_result  <= '0;
      out_loaded_data <= '0;
      out_dest_reg    <= '0;
      out_opcode      <= '0;
      out_misaligned  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          alu_q <= in_alu_result;
          rd_q  <= in_dest_reg;
          op_q  <= in_opcode;
          f3_q  <= in_funct3;
          off_q <= in_alu_result[1:0];
          if (!(is_load || is_store) || misaligned) begin
            // Complete immediately: nothing to fetch or write.
            out_valid       <= 1'b1;
            out_alu_result  <= in_alu_result;
            out_opcode      <= in_opcode;
            out_misaligned  <= misaligned;
            out_dest_reg    <= misaligned ? 5'd0 : in_dest_reg;
            out_loaded_data <= (in_opcode == OP_LUI) ? in_alu_result : '0;
          end else begin
            state          <= REQ;
            dmem_req_valid <= 1'b1;
            dmem_req_addr  <= {in_alu_result[XLEN-1:2], 2'b00};
            dmem_req_we    <= is_store;
            dmem_req_be    <= is_store ? st_be : 4'b0000;
            dmem_req_wdata <= is_store ? st_wdata : '0;
          end
        end
        REQ: if (dmem_req_ready) begin
          dmem_req_valid <= 1'b0;
          if (dmem_req_we) begin
            state           <= IDLE;
            out_valid       <= 1'b1;
            out_alu_result  <= alu_q;
            out_opcode      <= op_q;
            out_dest_reg    <= rd_q;
            out_misaligned  <= 1'b0;
            out_loaded_data <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dmem_resp_valid) begin
          state           <= IDLE;
          out_valid       <= 1'b1;
          out_alu_result  <= alu_q;
          out_opcode      <= op_q;
          out_dest_reg    <= rd_q;
          out_misaligned  <= 1'b0;
          out_loaded_data <= ld_ext;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: scenario tasks drive stimulus and push expected
// write_back payloads; a negedge monitor pops and compares them on each out_valid.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_dest_reg;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        out_valid;
  logic [31:0] out_alu_result;
  logic [31:0] out_loaded_data;
  logic [4:0]  out_dest_reg;
  logic [6:0]  out_opcode;
  logic        out_misaligned;

  int   passed = 0;
  int   total  = 0;
  int   n_out  = 0;
  exp_t exp_q[$];

  mem_access_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_dest_reg(in_dest_reg), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .out_valid(out_valid), .out_alu_result(out_alu_result),
    .out_loaded_data(out_loaded_data), .out_dest_reg(out_dest_reg),
    .out_opcode(out_opcode), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  // Scoreboard: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t act;
      exp_t e;
      n_out++;
      total++;
      act = {out_alu_result, out_loaded_data, out_dest_reg, out_opcode, out_misaligned};
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_out_valid: got alu=%h ld=%h rd=%0d, required no pulse",
                 out_alu_result, out_loaded_data, out_dest_reg);
      end else begin
        e = exp_q.pop_front();
        if (act !== e)
          $display("FAIL out_payload: got alu=%h ld=%h rd=%0d op=%b mis=%b, required alu=%h ld=%h rd=%0d op=%b mis=%b",
                   act.alu, act.ld, act.rd, act.op, act.mis, e.alu, e.ld, e.rd, e.op, e.mis);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_funct3     = f3;
    in_alu_result = alu;
    in_store_data = sd;
    in_dest_reg   = rd;
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else passed++;
    total++;
    if ({dmem_req_valid, dmem_req_we, dmem_req_be, dmem_req_addr, dmem_req_wdata} !== 70'd0)
      $display("FAIL reset_dmem: got v=%b we=%b be=%b addr=%h wd=%h required all 0",
               dmem_req_valid, dmem_req_we, dmem_req_be, dmem_req_addr, dmem_req_wdata);
    else passed++;
    total++;
    if ({out_valid, out_misaligned, out_alu_result, out_loaded_data, out_dest_reg, out_opcode} !== 78'd0)
      $display("FAIL reset_out: got v=%b mis=%b alu=%h ld=%h rd=%0d op=%b required all 0",
               out_valid, out_misaligned, out_alu_result, out_loaded_data, out_dest_reg, out_opcode);
    else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_nonmem();
    present(OP_ADD, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    exp_q.push_back('{alu: 32'h0000_1234, ld: 32'h0, rd: 5'd5, op: OP_ADD, mis: 1'b0});
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, dmem_req_valid, in_ready} !== 3'b101)
      $display("FAIL add_latency: got out_valid=%b req_valid=%b in_ready=%b required 1 0 1",
               out_valid, dmem_req_valid, in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL add_single_pulse: got out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_lui();
    present(OP_LUI, 3'b000, 32'hDEAD_B000, 32'h0, 5'd3);
    exp_q.push_back('{alu: 32'hDEAD_B000, ld: 32'hDEAD_B000, rd: 5'd3, op: OP_LUI, mis: 1'b0});
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL lui_latency: got out_valid=%b required 1", out_valid);
    else passed++;
    step();
  endtask

  // Load with ready in the first REQ cycle and response one cycle later; optionally
  // drive a bogus response during the handshake cycle, which must be ignored.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp_ld, input bit junk);
    present(OP_LOAD, f3, addr, 32'hFFFF_FFFF, 5'd9);
    exp_q.push_back('{alu: addr, ld: exp_ld, rd: 5'd9, op: OP_LOAD, mis: 1'b0});
    step();
    in_valid = 1'b0;
    total++;
    if ({dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, in_ready} !== {1'b1, addr & 32'hFFFF_FFFC, 1'b0, 4'b0000, 1'b0})
      $display("FAIL %s_req: got v=%b addr=%h we=%b be=%b in_ready=%b required 1 %h 0 0000 0",
               name, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, in_ready, addr & 32'hFFFF_FFFC);
    else passed++;
    dmem_req_ready = 1'b1;
    if (junk) begin
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = ~word;
    end
    step();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    total++;
    if ({dmem_req_valid, out_valid} !== 2'b00)
      $display("FAIL %s_wait: got req_valid=%b out_valid=%b required 0 0", name, dmem_req_valid, out_valid);
    else passed++;
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = word;
    step();
    dmem_resp_valid = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b11)
      $display("FAIL %s_latency: got out_valid=%b in_ready=%b required 1 1", name, out_valid, in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL %s_single_pulse: got out_valid=%b required 0", name, out_valid);
    else passed++;
  endtask

  task automatic test_loads();
    do_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080, 1'b0);
    do_load("lh",  3'b001, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF, 1'b0);
    do_load("lhu", 3'b101, 32'h0000_0100, 32'h1234_8001, 32'h0000_8001, 1'b0);
    do_load("lb0", 3'b000, 32'h0000_0104, 32'h0000_0071, 32'h0000_0071, 1'b0);
  endtask

  task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    present(OP_STORE, f3, addr, rs2, 5'd4);
    exp_q.push_back('{alu: addr, ld: 32'h0, rd: 5'd4, op: OP_STORE, mis: 1'b0});
    step();
    in_valid = 1'b0;
    total++;
    if ({dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata} !== {1'b1, addr & 32'hFFFF_FFFC, 1'b1, exp_be, exp_wd})
      $display("FAIL %s_req: got v=%b addr=%h we=%b be=%b wd=%h required 1 %h 1 %b %h",
               name, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
               addr & 32'hFFFF_FFFC, exp_be, exp_wd);
    else passed++;
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    total++;
    if ({out_valid, dmem_req_valid, in_ready} !== 3'b101)
      $display("FAIL %s_latency: got out_valid=%b req_valid=%b in_ready=%b required 1 0 1",
               name, out_valid, dmem_req_valid, in_ready);
    else passed++;
    step();
  endtask

  task automatic test_store();
    do_store("sh", 3'b001, 32'h0000_0202, 32'hABCD_1234, 4'b1100, 32'h1234_1234);
    do_store("sb", 3'b000, 32'h0000_0101, 32'h0000_0055, 4'b0010, 32'h5555_5555);
    do_store("sw", 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
  endtask

  task automatic do_misaligned(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] addr);
    present(op, f3, addr, 32'h5A5A_5A5A, 5'd11);
    exp_q.push_back('{alu: addr, ld: 32'h0, rd: 5'd0, op: op, mis: 1'b1});
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, dmem_req_valid, in_ready} !== 3'b101)
      $display("FAIL %s_misaligned: got out_valid=%b req_valid=%b in_ready=%b required 1 0 1",
               name, out_valid, dmem_req_valid, in_ready);
    else passed++;
    step();
    total++;
    if ({out_valid, dmem_req_valid} !== 2'b00)
      $display("FAIL %s_misaligned_after: got out_valid=%b req_valid=%b required 0 0",
               name, out_valid, dmem_req_valid);
    else passed++;
  endtask

  task automatic test_misaligned();
    do_misaligned("lw",  OP_LOAD,  3'b010, 32'h0000_0301);
    do_misaligned("sh",  OP_STORE, 3'b001, 32'h0000_0201);
    do_misaligned("f11", OP_LOAD,  3'b011, 32'h0000_0400);
  endtask

  task automatic test_stall();
    int n0 = n_out;
    present(OP_LOAD, 3'b010, 32'h0000_0404, 32'h0, 5'd17);
    exp_q.push_back('{alu: 32'h0000_0404, ld: 32'h1122_3344, rd: 5'd17, op: OP_LOAD, mis: 1'b0});
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_req_ready = 1'b1;
      total++;
      if ({dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, in_ready} !== {1'b1, 32'h0000_0404, 1'b0, 4'b0000, 1'b0})
        $display("FAIL stall_req_hold%0d: got v=%b addr=%h we=%b be=%b in_ready=%b required 1 00000404 0 0000 0",
                 i, dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, in_ready);
      else passed++;
      step();
    end
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, in_ready, dmem_req_valid} !== 3'b000)
        $display("FAIL stall_wait%0d: got out_valid=%b in_ready=%b req_valid=%b required 0 0 0",
                 i, out_valid, in_ready, dmem_req_valid);
      else passed++;
      step();
    end
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'h1122_3344;
    step();
    dmem_resp_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL stall_out: got out_valid=%b required 1", out_valid);
    else passed++;
    step();
    total++;
    if (n_out - n0 !== 1) $display("FAIL stall_pulse_count: got %0d required 1", n_out - n0);
    else passed++;
  endtask

  // A held in_valid while busy is ignored, and is accepted in the load's out_valid cycle.
  task automatic test_back_to_back();
    present(OP_LOAD, 3'b010, 32'h0000_0500, 32'h0, 5'd12);
    exp_q.push_back('{alu: 32'h0000_0500, ld: 32'hCAFE_BABE, rd: 5'd12, op: OP_LOAD, mis: 1'b0});
    step();
    present(OP_ADD, 3'b000, 32'h0000_0077, 32'h0, 5'd13);
    total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_busy_ready: got %b required 0", in_ready);
    else passed++;
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'hCAFE_BABE;
    step();
    dmem_resp_valid = 1'b0;
    exp_q.push_back('{alu: 32'h0000_0077, ld: 32'h0, rd: 5'd13, op: OP_ADD, mis: 1'b0});
    total++;
    if ({out_valid, in_ready} !== 2'b11)
      $display("FAIL b2b_overlap: got out_valid=%b in_ready=%b required 1 1", out_valid, in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL b2b_second_out: got out_valid=%b required 1", out_valid);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    present(OP_LOAD, 3'b010, 32'h0000_0600, 32'h0, 5'd21);
    step();
    in_valid       = 1'b0;
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({in_ready, dmem_req_valid, out_valid} !== 3'b100)
      $display("FAIL reset_mid_state: got in_ready=%b req_valid=%b out_valid=%b required 1 0 0",
               in_ready, dmem_req_valid, out_valid);
    else passed++;
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'h0000_0001;
    step();
    dmem_resp_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_mid_stale_resp: got out_valid=%b required 0", out_valid);
    else passed++;
    step();
  endtask

  initial begin
    reset           = 1'b1;
    in_valid        = 1'b0;
    in_alu_result   = '0;
    in_store_data   = '0;
    in_dest_reg     = '0;
    in_opcode       = '0;
    in_funct3       = '0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;

    test_reset();
    test_nonmem();
    test_lui();
    test_loads();
    test_store();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_mid();

    repeat (3) step();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
